// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction-RAM read master. Holds the PC, issues
//                synchronous reads, captures each returned word and presents
//                it to the control unit with a valid/ack handshake. Taken
//                branches redirect the PC using word offsets relative to the
//                instruction that follows the branch.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
   parameter int ADDRESS_BUS_WIDTH = 12,
   parameter int INSTRUCTION_WIDTH = 29,
   parameter int RESET_PC          = 0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         fetch_en,
   input  logic                         instr_ack,
   input  logic                         branch_taken,
   input  logic [ADDRESS_BUS_WIDTH-1:0] branch_offset,
   output logic [ADDRESS_BUS_WIDTH-1:0] ram_address,
   output logic                         ram_read_not_write,
   input  logic [INSTRUCTION_WIDTH-1:0] ram_data,
   output logic                         instr_valid,
   output logic [INSTRUCTION_WIDTH-1:0] instr_out,
   output logic [ADDRESS_BUS_WIDTH-1:0] pc_out
);

   localparam int AW = ADDRESS_BUS_WIDTH;
   localparam int IW = INSTRUCTION_WIDTH;

   // Word-aligned reset PC; ack_pc starts one word earlier so that a branch
   // taken before any ack resolves relative to RESET_PC.
   localparam logic [AW-1:0] C_RESET_PC_RAW = AW'(RESET_PC);
   localparam logic [AW-1:0] C_RESET_PC     = {C_RESET_PC_RAW[AW-1:2], 2'b00};
   localparam logic [AW-1:0] C_FOUR         = AW'(4);
   localparam logic [AW-1:0] C_RESET_ACK_PC = C_RESET_PC - C_FOUR;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      VALID   = 2'd3
   } state_t;

   state_t          state_q,       state_d;
   logic [AW-1:0]   pc_q,          pc_d;
   logic [AW-1:0]   ack_pc_q,      ack_pc_d;
   logic            instr_valid_q, instr_valid_d;
   logic [IW-1:0]   instr_q,       instr_d;
   logic [AW-1:0]   pc_out_q,      pc_out_d;

   logic            w_ack;
   logic [AW-1:0]   w_base;
   logic [AW-1:0]   w_offset_bytes;
   logic [AW-1:0]   w_target_raw;
   logic [AW-1:0]   w_target;

   // The PC always drives the RAM address; this unit never writes.
   assign ram_address        = pc_q;
   assign ram_read_not_write = 1'b1;
   assign instr_valid        = instr_valid_q;
   assign instr_out          = instr_q;
   assign pc_out             = pc_out_q;

   // Branch target: base + 4 + (signed word offset * 4), modulo 2^AW.
   always_comb begin
      w_ack          = instr_ack & instr_valid_q;
      w_base         = w_ack ? pc_out_q : ack_pc_q;
      w_offset_bytes = branch_offset << 2;
      w_target_raw   = w_base + C_FOUR + w_offset_bytes;
      w_target       = {w_target_raw[AW-1:2], 2'b00};
   end

   // State register and datapath registers; reset takes effect immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         pc_q          <= C_RESET_PC;
         ack_pc_q      <= C_RESET_ACK_PC;
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         pc_out_q      <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ack_pc_q      <= ack_pc_d;
         instr_valid_q <= instr_valid_d;
         instr_q       <= instr_d;
         pc_out_q      <= pc_out_d;
      end
   end

   // Next-state logic: a taken branch overrides everything else, in any state.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ack_pc_d      = ack_pc_q;
      instr_valid_d = instr_valid_q;
      instr_d       = instr_q;
      pc_out_d      = pc_out_q;

      if (branch_taken) begin
         // An ack in the same cycle is still honoured for ack_pc; the pending
         // fetch (if any) is dropped by restarting from ISSUE/IDLE.
         if (w_ack) begin
            ack_pc_d = pc_out_q;
         end
         pc_d          = w_target;
         instr_valid_d = 1'b0;
         state_d       = fetch_en ? ISSUE : IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (fetch_en) begin
                  state_d = ISSUE;
               end
            end
            ISSUE: begin
               // RAM samples the address at this edge.
               state_d = CAPTURE;
            end
            CAPTURE: begin
               instr_d       = ram_data;
               pc_out_d      = pc_q;
               instr_valid_d = 1'b1;
               state_d       = VALID;
            end
            VALID: begin
               if (w_ack) begin
                  instr_valid_d = 1'b0;
                  ack_pc_d      = pc_out_q;
                  pc_d          = pc_q + C_FOUR;
                  state_d       = fetch_en ? ISSUE : IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed self-checking bench for instr_fetch_unit with a
//                synchronous-read instruction RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   localparam int AW = 12;
   localparam int IW = 29;

   logic          clk;
   logic          reset_n;
   logic          fetch_en;
   logic          instr_ack;
   logic          branch_taken;
   logic [AW-1:0] branch_offset;
   logic [AW-1:0] ram_address;
   logic          ram_read_not_write;
   logic [IW-1:0] ram_data;
   logic          instr_valid;
   logic [IW-1:0] instr_out;
   logic [AW-1:0] pc_out;

   int errors = 0;
   int checks = 0;

   logic [IW-1:0] mem [0:1023];

   instr_fetch_unit #(
      .ADDRESS_BUS_WIDTH (AW),
      .INSTRUCTION_WIDTH (IW),
      .RESET_PC          (0)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .fetch_en           (fetch_en),
      .instr_ack          (instr_ack),
      .branch_taken       (branch_taken),
      .branch_offset      (branch_offset),
      .ram_address        (ram_address),
      .ram_read_not_write (ram_read_not_write),
      .ram_data           (ram_data),
      .instr_valid        (instr_valid),
      .instr_out          (instr_out),
      .pc_out             (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read RAM: data appears one clock after the address is sampled.
   always @(posedge clk) ram_data <= mem[ram_address[AW-1:2]];

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait 'zeros' edges with instr_valid low, then one edge that presents the word.
   task automatic expect_fetch(input int zeros, input logic [AW-1:0] pc, input logic [IW-1:0] instr);
      for (int i = 0; i < zeros; i++) begin
         tick();
         check("lat_valid_low", 32'(instr_valid), 32'd0);
      end
      tick();
      check("valid_high", 32'(instr_valid), 32'd1);
      check("instr_out", 32'(instr_out), 32'(instr));
      check("pc_out", 32'(pc_out), 32'(pc));
   endtask

   // Acknowledge the presented word, optionally with a taken branch.
   task automatic do_ack(input logic br, input logic [AW-1:0] off, input logic [AW-1:0] next_addr);
      instr_ack     = 1'b1;
      branch_taken  = br;
      branch_offset = off;
      tick();
      instr_ack     = 1'b0;
      branch_taken  = 1'b0;
      branch_offset = '0;
      check("ack_valid_low", 32'(instr_valid), 32'd0);
      check("next_addr", 32'(ram_address), 32'(next_addr));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = IW'(32'h1000000 | i);
      mem[0] = 29'h1100010;
      mem[1] = 29'h1200020;
      mem[2] = 29'h3312000;
      mem[3] = 29'h2003030;
      mem[7] = 29'h0700007;
      mem[8] = 29'h0800008;
      mem[9] = 29'hA023FFD;

      reset_n       = 1'b0;
      fetch_en      = 1'b0;
      instr_ack     = 1'b0;
      branch_taken  = 1'b0;
      branch_offset = '0;
      tick();
      tick();

      // Reset state
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", 32'(instr_out), 32'd0);
      check("rst_pc_out", 32'(pc_out), 32'd0);
      check("rst_addr", 32'(ram_address), 32'd0);
      check("rst_rnw", 32'(ram_read_not_write), 32'd1);
      reset_n = 1'b1;

      // Idle without fetch_en
      tick();
      tick();
      check("idle_valid", 32'(instr_valid), 32'd0);
      check("idle_addr", 32'(ram_address), 32'd0);

      // Sequential fetch of words 0..3, ack in first VALID cycle
      fetch_en = 1'b1;
      expect_fetch(2, 12'h000, 29'h1100010);
      do_ack(1'b0, '0, 12'h004);
      expect_fetch(1, 12'h004, 29'h1200020);
      do_ack(1'b0, '0, 12'h008);
      expect_fetch(1, 12'h008, 29'h3312000);
      do_ack(1'b0, '0, 12'h00C);
      expect_fetch(1, 12'h00C, 29'h2003030);

      // Stall in VALID for 10 cycles: everything holds
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_valid", 32'(instr_valid), 32'd1);
         check("hold_instr", 32'(instr_out), 32'h2003030);
         check("hold_pc_out", 32'(pc_out), 32'h00C);
         check("hold_addr", 32'(ram_address), 32'h00C);
         check("hold_rnw", 32'(ram_read_not_write), 32'd1);
      end

      // Branch with ack: 0x00C + 4 + 5*4 = 0x024 (word 9)
      do_ack(1'b1, 12'd5, 12'h024);
      expect_fetch(1, 12'h024, 29'hA023FFD);
      // Backward loop: 0x024 + 4 - 3*4 = 0x01C
      do_ack(1'b1, 12'hFFD, 12'h01C);
      expect_fetch(1, 12'h01C, 29'h0700007);
      do_ack(1'b0, '0, 12'h020);
      expect_fetch(1, 12'h020, 29'h0800008);
      do_ack(1'b0, '0, 12'h024);
      expect_fetch(1, 12'h024, 29'hA023FFD);
      do_ack(1'b1, 12'hFFD, 12'h01C);
      expect_fetch(1, 12'h01C, 29'h0700007);
      do_ack(1'b0, '0, 12'h020);
      expect_fetch(1, 12'h020, 29'h0800008);
      do_ack(1'b0, '0, 12'h024);   // ack_pc = 0x020, now in ISSUE

      // Branch in CAPTURE without ack: 0x020 + 4 + 2*4 = 0x02C
      tick();
      check("cap_valid_low", 32'(instr_valid), 32'd0);
      branch_taken  = 1'b1;
      branch_offset = 12'd2;
      tick();
      branch_taken  = 1'b0;
      branch_offset = '0;
      check("br_cap_valid", 32'(instr_valid), 32'd0);
      check("br_cap_addr", 32'(ram_address), 32'h02C);
      expect_fetch(1, 12'h02C, 29'h100000B);

      // Jump to 0xFFC: 0x02C + 4 + 0x3F3*4 = 0xFFC, then wrap to 0x000
      do_ack(1'b1, 12'h3F3, 12'hFFC);
      expect_fetch(1, 12'hFFC, 29'h10003FF);
      do_ack(1'b0, '0, 12'h000);
      expect_fetch(1, 12'h000, 29'h1100010);
      do_ack(1'b0, '0, 12'h004);   // now in ISSUE at 0x004

      // Asynchronous reset in ISSUE takes effect without a clock edge
      reset_n = 1'b0;
      #1;
      check("arst_valid", 32'(instr_valid), 32'd0);
      check("arst_addr", 32'(ram_address), 32'h000);
      check("arst_instr", 32'(instr_out), 32'd0);
      check("arst_pc_out", 32'(pc_out), 32'd0);
      #1;
      reset_n = 1'b1;
      expect_fetch(2, 12'h000, 29'h1100010);

      // fetch_en dropped: unit idles after the ack
      fetch_en = 1'b0;
      do_ack(1'b0, '0, 12'h004);
      tick();
      tick();
      tick();
      check("idle2_valid", 32'(instr_valid), 32'd0);
      check("idle2_addr", 32'(ram_address), 32'h004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Read-side master for the instruction RAM. It holds the program counter, drives the RAM address and read_not_write strobe, and captures each synchronous-read word. It presents the fetched instruction to the multicycle control unit with a valid/ack handshake. It also applies taken-branch redirects, using word offsets relative to the instruction that follows the branch.

Parameters:
ADDRESS_BUS_WIDTH, 12, byte-address width of the PC and ram_address
INSTRUCTION_WIDTH, 29, instruction word width
RESET_PC, 0, byte address loaded into the PC on reset (bits [1:0] must be 0)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
fetch_en  input  1  high: unit may start or continue fetching; low: unit goes idle after the current instruction is consumed
instr_ack  input  1  control unit consumes instr_out this cycle (honoured only while instr_valid=1)
branch_taken  input  1  one-cycle pulse: redirect the PC
branch_offset  input  ADDRESS_BUS_WIDTH  signed word offset for the branch target
ram_address  output  ADDRESS_BUS_WIDTH  byte address to the instruction RAM
ram_read_not_write  output  1  RAM direction strobe; always 1 from this unit
ram_data  input  INSTRUCTION_WIDTH  RAM read data, valid one clock after the address is sampled
instr_valid  output  1  instr_out/pc_out hold a fetched instruction
instr_out  output  INSTRUCTION_WIDTH  fetched instruction, registered
pc_out  output  ADDRESS_BUS_WIDTH  byte address of instr_out

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pc=RESET_PC, ack_pc=RESET_PC-4.
  - instr_valid=0, instr_out=0, pc_out=0, ram_address=RESET_PC, ram_read_not_write=1.
  - Outputs change immediately on reset assertion, not at the next edge; any in-flight fetch is lost.
- ram_address is combinational from pc in every state; ram_read_not_write is tied to 1.
- States and transitions:
  - IDLE: if fetch_en, go to ISSUE.
  - ISSUE: pc is on ram_address; the RAM registers the word at this edge; go to CAPTURE.
  - CAPTURE: ram_data is valid; latch instr_out<=ram_data and pc_out<=pc; set instr_valid; go to VALID.
  - VALID: hold all outputs stable until instr_ack. On ack: instr_valid<=0, ack_pc<=pc_out, pc<=pc+4; go to ISSUE if fetch_en, else IDLE.
- Latency and throughput:
  - fetch_en sampled high in IDLE at edge E0 -> instr_valid=1 after edge E2.
  - Back-to-back throughput with ack in the first VALID cycle is one instruction per 3 cycles.
- PC arithmetic:
  - Modulo 2^ADDRESS_BUS_WIDTH; increment is +4, so 0xFFC wraps to 0x000.
  - PC bits [1:0] are always 0; any computed target has bits [1:0] forced to 0.
- Branch target = base + 4 + (sign_extend(branch_offset) << 2), modulo 2^ADDRESS_BUS_WIDTH.
  - base = pc_out if instr_ack is asserted in the same cycle (the branch belongs to the instruction being consumed); otherwise base = ack_pc.
- branch_taken in any state: pc<=target; instr_valid<=0.
  - If fetch_en, go to ISSUE; otherwise go to IDLE.
  - Any in-flight fetch (ISSUE or CAPTURE) is discarded, and its data is never presented.
- branch_taken with instr_ack in VALID: the ack is honoured (ack_pc<=pc_out), the branch wins for pc (no +4), and the next state is ISSUE if fetch_en, else IDLE.
- fetch_en dropping in ISSUE or CAPTURE: the fetch completes and is presented; the unit then idles after the ack.
- instr_ack while instr_valid=0 is ignored.

Test Plan:
- Reset then fetch_en=1, RAM words 0..3 = 0x1100010, 0x1200020, 0x3312000, 0x2003030, ack each in the first VALID cycle -> instr_out sequence matches, pc_out = 0x000/0x004/0x008/0x00C, instr_valid first high 2 edges after fetch_en, then every 3 cycles.
- Start at RESET_PC=0x010 with word 9 = 0xA023FFD; ack word 9 with branch_taken=1, branch_offset=0xFFD (-3) -> next pc_out=0x01C (word 7); the loop repeats correctly.
- branch_taken in CAPTURE with ack_pc=0x020, offset=+2 -> captured word discarded, next instr_out from 0x02C, no spurious instr_valid.
- Hold instr_ack=0 for 10 cycles in VALID -> instr_out/pc_out stable, ram_read_not_write=1 throughout, pc unchanged.
- PC=0xFFC acked -> next fetch address 0x000; reset_n pulsed low in ISSUE -> instr_valid=0 immediately, ram_address=RESET_PC, and fetching restarts from RESET_PC.
